// File: rtl/instr_loader.sv
// Serial-link instruction loader: receives a length byte, big-endian 16-bit words
// and an XOR checksum byte, and writes each word into instruction memory.
module instr_loader (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [7:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        busy,
   output logic        load_done,
   output logic        chk_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] len_q, len_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] csum_q, csum_d;
   logic [7:0] hi_q, hi_d;
   logic [7:0] lo_q, lo_d;
   logic       load_done_q, load_done_d;
   logic       chk_err_q, chk_err_d;
   logic       accept;

   assign byte_ready = (state_q == S_LEN) || (state_q == S_HI) ||
                       (state_q == S_LO)  || (state_q == S_CHK);
   assign accept     = byte_valid && byte_ready;
   assign busy       = (state_q != S_IDLE);
   assign wr_en      = (state_q == S_WR);
   // Write bus is forced to zero outside WR so a quiescent loader drives all-zero outputs.
   assign wr_addr    = wr_en ? addr_q : 8'h00;
   assign wr_data    = wr_en ? {hi_q, lo_q} : 16'h0000;
   assign load_done  = load_done_q;
   assign chk_err    = chk_err_q;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      load_done_d = load_done_q;
      chk_err_d   = chk_err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LEN;
               addr_d      = 8'h00;
               cnt_d       = 8'h00;
               csum_d      = 8'h00;
               load_done_d = 1'b0;
               chk_err_d   = 1'b0;
            end
         end
         S_LEN: begin
            if (accept) begin
               len_d   = byte_in;
               csum_d  = csum_q ^ byte_in;
               state_d = (byte_in == 8'h00) ? S_CHK : S_HI;
            end
         end
         S_HI: begin
            if (accept) begin
               hi_d    = byte_in;
               csum_d  = csum_q ^ byte_in;
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (accept) begin
               lo_d    = byte_in;
               csum_d  = csum_q ^ byte_in;
               state_d = S_WR;
            end
         end
         S_WR: begin
            addr_d  = addr_q + 8'd1;
            cnt_d   = cnt_q + 8'd1;
            state_d = ((cnt_q + 8'd1) == len_q) ? S_CHK : S_HI;
         end
         S_CHK: begin
            if (accept) begin
               chk_err_d   = (byte_in != csum_q);
               load_done_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= 8'h00;
         addr_q      <= 8'h00;
         cnt_q       <= 8'h00;
         csum_q      <= 8'h00;
         load_done_q <= 1'b0;
         chk_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         load_done_q <= load_done_d;
         chk_err_q   <= chk_err_d;
      end
   end

   // Word assembly bytes are only observed in WR, which reset always leaves.
   always_ff @(posedge clk) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
   end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port `start`, input, 1 bit: a 1-cycle pulse that begins a load session.
REQ-004 SHALL have port `byte_in`, input, 8 bits: the serial-link byte.
REQ-005 SHALL have port `byte_valid`, input, 1 bit: `byte_in` holds a valid byte.
REQ-006 SHALL have port `byte_ready`, output, 1 bit: the loader can accept a byte this cycle.
REQ-007 SHALL have port `wr_en`, output, 1 bit: instruction-memory write strobe.
REQ-008 SHALL have port `wr_addr`, output, 8 bits: instruction-memory write address.
REQ-009 SHALL have port `wr_data`, output, 16 bits: instruction word to write.
REQ-010 SHALL have port `busy`, output, 1 bit: a session is in progress; the CPU is held off while it is high.
REQ-011 SHALL have port `load_done`, output, 1 bit: the last session has completed.
REQ-012 SHALL have port `chk_err`, output, 1 bit: the last session's checksum mismatched.

Function
REQ-013 A byte SHALL be accepted only in a cycle where `byte_valid` and `byte_ready` are both 1; when `byte_ready`=0 the byte is not consumed and the source holds it.
REQ-014 States SHALL be IDLE, LEN, HI, LO, WR, CHK, DONE.
REQ-015 IDLE: `byte_ready`=0 and `busy`=0; `start`=1 goes to LEN and clears the address counter, word counter, running checksum, `load_done` and `chk_err`.
REQ-016 LEN: `byte_ready`=1; an accepted byte is stored as length L (0..255) and XORed into the checksum.
REQ-016a LEN exit: L=0 goes to CHK; otherwise goes to HI.
REQ-017 HI: `byte_ready`=1; the accepted byte is the high byte of the word and is XORed into the checksum; then go to LO.
REQ-018 LO: `byte_ready`=1; the accepted byte is the low byte of the word and is XORed into the checksum; then go to WR.
REQ-019 WR: lasts exactly 1 cycle.
REQ-019a WR outputs: `byte_ready`=0, `wr_en`=1, `wr_addr`=address counter, `wr_data`={high byte, low byte}.
REQ-019b WR updates: address and word counters increment by 1.
REQ-019c WR exit: go to CHK if the word count now equals L; otherwise go to HI.
REQ-020 Write latency: `wr_en` SHALL assert in the cycle immediately after the LO byte is accepted.
REQ-021 Addresses SHALL run 0..L-1; since L≤255 the counter never wraps within a session, and the last possible address is 0xFE.
REQ-022 CHK: `byte_ready`=1; on acceptance, `chk_err` is set to 1 if the received byte ≠ the running XOR of L and all data bytes, else 0; then go to DONE.
REQ-023 DONE: lasts 1 cycle, then goes to IDLE.
REQ-023a `load_done` SHALL go to 1 on entry to DONE and stay 1 until the next accepted `start` or `reset`.
REQ-023b `chk_err` SHALL hold its value until the next accepted `start` or `reset`.
REQ-024 `busy`=1 in every state except IDLE.
REQ-025 `start` while `busy`=1 SHALL be ignored.
REQ-026 `byte_valid` in IDLE, WR or DONE SHALL be ignored.
REQ-027 A checksum mismatch SHALL NOT suppress or undo writes already issued; the CPU-side controller decides whether to run.
REQ-028 `wr_en` SHALL be 0 in every state except WR.
REQ-029 Outside WR, `wr_addr` and `wr_data` are don't-care.

Reset
REQ-030 `reset`=1 at a rising edge SHALL force IDLE and clear to 0: address counter, word counter, checksum, L, `load_done`, `chk_err`.
REQ-031 After reset, all outputs SHALL be 0 from the next cycle onward: `byte_ready`, `wr_en`, `wr_addr`, `wr_data`, `busy`.
REQ-032 Reset mid-session SHALL abort it.
REQ-032a After a mid-session reset, no further `wr_en` SHALL issue, and a partially assembled word SHALL be discarded.
REQ-033 `reset` SHALL take priority over `start` in the same cycle.

Verification
REQ-034 Nominal load: reset; start; bytes 02,12,34,AB,CD,42 -> `wr_en` addr 00 data 1234, then addr 01 data ABCD; then `load_done`=1, `chk_err`=0, `busy`=0.
REQ-035 Bad checksum: same stream, checksum byte 43 -> both writes still occur; `load_done`=1, `chk_err`=1.
REQ-036 Empty load: start; bytes 00,00 -> no `wr_en`; `load_done`=1, `chk_err`=0.
REQ-037 Reset mid-word: start; bytes 02,12; `reset` for 1 cycle -> next cycle `busy`=0; no `wr_en` ever issues.
REQ-037a Restart after reset: a new start with the REQ-034 stream writes starting at addr 00 again.
REQ-038 Gaps and ignored start: REQ-034 stream with random 0–3-cycle `byte_valid` gaps and a `start` pulse mid-session -> output identical to REQ-034.
REQ-039 Max length: L=FF; data byte pairs {n, ~n} for n=0..FE; correct checksum -> 255 writes, last write addr FE data FE01; `chk_err`=0.
